stream_divider: RTL and testbench

STREAM_DIVIDER -- requirements
Module: stream_divider

---
 rtl/stream_divider.sv | 128 ++++++++++++
 tb/tb_stream_divider.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_divider.sv
// Pipelined restoring divider: STAGES register stages, each resolving DATA_LEN/STAGES quotient bits.
// Define STREAM_DIVIDER_SIGNED_EN to compile in two's-complement operand handling.
module stream_divider #(
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned STAGES   = 8,
   parameter int unsigned ID_W     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] in_a,
   input  logic [DATA_LEN-1:0] in_b,
   input  logic                in_signed,
   input  logic [ID_W-1:0]     in_id,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_quot,
   output logic [DATA_LEN-1:0] out_rem,
   output logic                out_dbz,
   output logic [ID_W-1:0]     out_id
);

   localparam int unsigned BPS  = DATA_LEN / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   typedef struct packed {
      logic                valid;
      logic [ID_W-1:0]     id;
      logic                neg_q;
      logic                neg_r;
      logic                dbz;
      logic [DATA_LEN-1:0] dvs;
      logic [DATA_LEN-1:0] rem;
      logic [DATA_LEN-1:0] quo;
   } stage_t;

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];
   stage_t beat_in;
   logic   advance;

   // quo starts as the dividend; its bits shift out into rem as quotient bits shift in
   function automatic stage_t iterate(input stage_t s);
      stage_t            r;
      logic [DATA_LEN:0] trial;
      r = s;
      for (int unsigned i = 0; i < BPS; i++) begin
         trial = {r.rem, r.quo[DATA_LEN-1]};
         r.quo = r.quo << 1;
         if (trial >= {1'b0, r.dvs}) begin
            trial    = trial - {1'b0, r.dvs};
            r.quo[0] = 1'b1;
         end
         r.rem = trial[DATA_LEN-1:0];
      end
      return r;
   endfunction

   function automatic stage_t finish(input stage_t s);
      stage_t r;
      r = s;
`ifdef STREAM_DIVIDER_SIGNED_EN
      if (r.neg_q) r.quo = -r.quo;
      if (r.neg_r) r.rem = -r.rem;
`endif
      if (r.dbz) r.quo = '1;
      return r;
   endfunction

`ifndef STREAM_DIVIDER_SIGNED_EN
   logic unused_signed;
   always_comb unused_signed = in_signed;
`endif

   always_comb begin
      beat_in       = '0;
      beat_in.valid = in_valid;
      beat_in.id    = in_id;
      beat_in.dbz   = (in_b == '0);
      beat_in.quo   = in_a;
      beat_in.dvs   = in_b;
`ifdef STREAM_DIVIDER_SIGNED_EN
      // Magnitudes are divided; a zero divisor still restores rem to a via neg_r
      if (in_signed) begin
         beat_in.neg_q = in_a[DATA_LEN-1] ^ in_b[DATA_LEN-1];
         beat_in.neg_r = in_a[DATA_LEN-1];
         if (in_a[DATA_LEN-1]) beat_in.quo = -in_a;
         if (in_b[DATA_LEN-1]) beat_in.dvs = -in_b;
      end
`endif
   end

   always_comb begin
      stage_d[0] = iterate(beat_in);
      for (int unsigned s = 1; s < STAGES; s++) begin
         stage_d[s] = iterate(stage_q[s-1]);
      end
      stage_d[LAST] = finish(stage_d[LAST]);
   end

   // Reset is folded in so in_ready stays high while the pipeline is being flushed
   always_comb begin
      advance  = reset || !stage_q[LAST].valid || out_ready;
      in_ready = advance;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            stage_q[s] <= '0;
         end
      end else if (advance) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            stage_q[s] <= stage_d[s];
         end
      end
   end

   always_comb begin
      out_valid = stage_q[LAST].valid;
      out_quot  = stage_q[LAST].quo;
      out_rem   = stage_q[LAST].rem;
      out_dbz   = stage_q[LAST].dbz;
      out_id    = stage_q[LAST].id;
   end

endmodule

// File: tb/tb_stream_divider.sv
// Scoreboard bench for stream_divider: expected results are queued on acceptance and popped on output handshake.
module tb_stream_divider;

   localparam int DL = 32;
   localparam int ST = 8;
   localparam int IW = 8;

   typedef logic [DL+DL+1+IW-1:0] res_t;  // {quot, rem, dbz, id}

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, in_signed;
   logic [DL-1:0] in_a, in_b;
   logic [IW-1:0] in_id;
   logic          out_valid, out_ready, out_dbz;
   logic [DL-1:0] out_quot, out_rem;
   logic [IW-1:0] out_id;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   always #5 clk = ~clk;

   stream_divider #(
      .DATA_LEN(DL),
      .STAGES  (ST),
      .ID_W    (IW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_signed(in_signed),
      .in_id    (in_id),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_quot (out_quot),
      .out_rem  (out_rem),
      .out_dbz  (out_dbz),
      .out_id   (out_id)
   );

   function automatic res_t model(input logic [DL-1:0] a, input logic [DL-1:0] b,
                                  input logic sgn, input logic [IW-1:0] id);
      logic [DL-1:0] q, r, min_v;
      logic          unused_sgn;
      unused_sgn = sgn;
      min_v = {1'b1, {(DL-1){1'b0}}};
      if (b == '0) return {{DL{1'b1}}, a, 1'b1, id};
      q = a / b;
      r = a % b;
`ifdef STREAM_DIVIDER_SIGNED_EN
      if (sgn) begin
         if (a == min_v && b == '1) begin
            q = min_v;
            r = '0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end
`endif
      return {q, r, 1'b0, id};
   endfunction

   // Drives one cycle of stimulus from posedge+1 and returns at the next posedge+1
   task automatic drive_cycle(input logic v, input logic [DL-1:0] a, input logic [DL-1:0] b,
                              input logic sgn, input logic [IW-1:0] id, input logic rdy,
                              output logic ir, output logic ov, output logic fire, output res_t obs);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_signed = sgn;
      in_id     = id;
      out_ready = rdy;
      #1;
      ir   = in_ready;
      ov   = out_valid;
      fire = out_valid && out_ready;
      obs  = {out_quot, out_rem, out_dbz, out_id};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sgn, id));
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_a = 32'd9; in_b = 32'd2;
      in_signed = 1'b0; in_id = 8'h55; out_ready = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_during got=%b required=1", in_ready); end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if ({out_valid, out_quot, out_rem, out_dbz, out_id} !== '0)
         begin errors++; $display("FAIL reset_outputs got v=%b q=%h r=%h dbz=%b id=%h required all zero",
                                  out_valid, out_quot, out_rem, out_dbz, out_id); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b required=1", in_ready); end
      for (int c = 0; c < ST + 2; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_dropped_beat out_valid=%b required=0", out_valid); end
      end
      #(-1 + 1);
   endtask

   task automatic test_basic();
      logic ir, ov, fire;
      res_t obs, e;
      int   lat;
      drive_cycle(1'b1, 32'd100, 32'd7, 1'b0, 8'd3, 1'b1, ir, ov, fire, obs);
      checks++;
      if (ir !== 1'b1) begin errors++; $display("FAIL basic_accept in_ready=%b required=1", ir); end
      lat = 0;
      fire = 1'b0;
      while (lat < 40 && !fire) begin
         drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, fire, obs);
         lat++;
      end
      checks++;
      if (lat !== ST) begin errors++; $display("FAIL basic_latency got=%0d required=%0d", lat, ST); end
      checks++;
      if (!fire || exp_q.size() == 0) begin
         errors++; $display("FAIL basic_timeout fire=%b queued=%0d required fire=1", fire, exp_q.size());
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin errors++; $display("FAIL basic_scoreboard got=%h required=%h", obs, e); end
         checks++;
         if (obs !== {32'd14, 32'd2, 1'b0, 8'd3})
            begin errors++; $display("FAIL basic_result got=%h required=%h", obs, {32'd14, 32'd2, 1'b0, 8'd3}); end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic ir, ov, fire;
      res_t obs, e;
      int   nfire, first, last;
      nfire = 0; first = -1; last = -1;
      for (int c = 0; c < 16 + 40 && nfire < 16; c++) begin
         drive_cycle(c < 16, DL'(1000 + c), 32'd3, 1'b0, IW'(c), 1'b1, ir, ov, fire, obs);
         if (c < 16) begin
            checks++;
            if (ir !== 1'b1) begin errors++; $display("FAIL b2b_accept beat=%0d in_ready=%b required=1", c, ir); end
         end
         if (fire) begin
            if (first < 0) first = c;
            last = c;
            nfire++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_spurious got=%h required=none", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin errors++; $display("FAIL b2b_result got=%h required=%h", obs, e); end
            end
         end
      end
      checks++;
      if (nfire !== 16 || last - first !== 15)
         begin errors++; $display("FAIL b2b_stream got=%0d results over %0d cycles required=16 over 16", nfire, last - first + 1); end
      exp_q.delete();
   endtask

   task automatic test_dbz();
      logic ir, ov, fire;
      res_t obs, e;
      int   c;
      drive_cycle(1'b1, 32'd5, 32'd0, 1'b0, 8'd9, 1'b1, ir, ov, fire, obs);
      c = 0;
      fire = 1'b0;
      while (c < 40 && !fire) begin
         drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, fire, obs);
         c++;
      end
      checks++;
      if (!fire || exp_q.size() == 0) begin
         errors++; $display("FAIL dbz_timeout fire=%b required=1", fire);
      end else begin
         e = exp_q.pop_front();
         if (obs !== e) begin errors++; $display("FAIL dbz_scoreboard got=%h required=%h", obs, e); end
         checks++;
         if (obs !== {32'hFFFF_FFFF, 32'd5, 1'b1, 8'd9})
            begin errors++; $display("FAIL dbz_result got=%h required=%h", obs, {32'hFFFF_FFFF, 32'd5, 1'b1, 8'd9}); end
      end
      exp_q.delete();
   endtask

   task automatic test_signed();
      logic          ir, ov, fire;
      res_t          obs, e;
      logic [DL-1:0] ta [4];
      logic [DL-1:0] tb [4];
      logic          ts [4];
      logic [DL-1:0] kq [4];
      logic [DL-1:0] kr [4];
      int            nfire;
      ta = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7};
      tb = '{32'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE};
      ts = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef STREAM_DIVIDER_SIGNED_EN
      kq = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFC, 32'hFFFF_FFFD};
      kr = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1};
`else
      kq = '{32'h7FFF_FFFC, 32'd0, 32'h7FFF_FFFC, 32'd0};
      kr = '{32'd1, 32'h8000_0000, 32'd1, 32'd7};
`endif
      nfire = 0;
      for (int c = 0; c < 50 && nfire < 4; c++) begin
         if (c < 4) drive_cycle(1'b1, ta[c], tb[c], ts[c], IW'(8'h20 + c), 1'b1, ir, ov, fire, obs);
         else       drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, fire, obs);
         if (fire) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL signed_spurious got=%h required=none", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin errors++; $display("FAIL signed_scoreboard got=%h required=%h", obs, e); end
            end
            checks++;
            if (obs !== {kq[nfire], kr[nfire], 1'b0, IW'(8'h20 + nfire)})
               begin errors++; $display("FAIL signed_result beat=%0d got q=%h r=%h id=%h required q=%h r=%h",
                                        nfire, obs[2*DL+IW:DL+IW+1], obs[DL+IW:IW+1], obs[IW-1:0], kq[nfire], kr[nfire]); end
            nfire++;
         end
      end
      checks++;
      if (nfire !== 4) begin errors++; $display("FAIL signed_count got=%0d required=4", nfire); end
      exp_q.delete();
   endtask

   task automatic test_stall();
      logic ir, ov, fire, v, rdy;
      res_t obs, e, frozen;
      int   nacc, nfire;
      nacc = 0; nfire = 0; frozen = '0;
      for (int c = 0; c < 80; c++) begin
         v   = (c < 20);
         rdy = !(c >= 12 && c < 17);
         if (c >= 20 && exp_q.size() == 0) break;
         drive_cycle(v, $urandom, DL'($urandom_range(1, 1000)), 1'b0, IW'(c), rdy, ir, ov, fire, obs);
         if (v && ir) nacc++;
         if (c == 12) frozen = obs;
         if (c >= 12 && c < 17) begin
            checks++;
            if (ir !== 1'b0 || ov !== 1'b1)
               begin errors++; $display("FAIL stall_ready cycle=%0d in_ready=%b out_valid=%b required 0 and 1", c, ir, ov); end
         end
         if (c > 12 && c < 17) begin
            checks++;
            if (obs !== frozen) begin errors++; $display("FAIL stall_frozen cycle=%0d got=%h required=%h", c, obs, frozen); end
         end
         if (fire) begin
            nfire++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stall_spurious got=%h required=none", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin errors++; $display("FAIL stall_result got=%h required=%h", obs, e); end
            end
         end
      end
      checks++;
      if (nfire !== nacc || exp_q.size() != 0)
         begin errors++; $display("FAIL stall_drain got=%0d results required=%0d (left %0d)", nfire, nacc, exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      logic ir, ov, fire;
      res_t obs, e;
      int   nfire;
      for (int c = 0; c < 6; c++) begin
         drive_cycle(c < 4, DL'(200 + c), 32'd9, 1'b0, IW'(8'h40 + c), 1'b1, ir, ov, fire, obs);
      end
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b required=1", in_ready); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b required=0", out_valid); end
      reset = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 2 * ST; c++) begin
         drive_cycle(1'b0, '0, '0, 1'b0, '0, 1'b1, ir, ov, fire, obs);
         checks++;
         if (ov !== 1'b0) begin errors++; $display("FAIL midreset_stale got=%h required=none", obs); end
      end
      nfire = 0;
      for (int c = 0; c < 40 && nfire == 0; c++) begin
         drive_cycle(c == 0, 32'd50, 32'd5, 1'b0, 8'h77, 1'b1, ir, ov, fire, obs);
         if (fire) begin
            nfire++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL midreset_spurious got=%h required=none", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin errors++; $display("FAIL midreset_fresh got=%h required=%h", obs, e); end
            end
         end
      end
      checks++;
      if (nfire !== 1) begin errors++; $display("FAIL midreset_fresh_count got=%0d required=1", nfire); end
      exp_q.delete();
   endtask

   task automatic test_random();
      logic          ir, ov, fire, v, rdy, sgn;
      logic [DL-1:0] a, b;
      res_t          obs, e;
      int            nacc, nfire;
      nacc = 0; nfire = 0;
      for (int c = 0; c < 400; c++) begin
         if (c >= 200 && exp_q.size() == 0) break;
         v   = (c < 200) && ($urandom_range(0, 3) != 0);
         rdy = (c >= 200) || ($urandom_range(0, 3) != 0);
         sgn = 1'b1 & $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       a = 32'h8000_0000;
            1:       a = DL'($urandom_range(0, 100));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = '0;
            1:       b = '1;
            2:       b = DL'($urandom_range(1, 16));
            3:       b = 32'hFFFF_FFF0 | DL'($urandom_range(0, 15));
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         drive_cycle(v, a, b, sgn, IW'($urandom), rdy, ir, ov, fire, obs);
         if (v && ir) nacc++;
         if (fire) begin
            nfire++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL random_spurious got=%h required=none", obs); end
            else begin
               e = exp_q.pop_front();
               if (obs !== e) begin errors++; $display("FAIL random_result got=%h required=%h", obs, e); end
            end
         end
      end
      checks++;
      if (nfire !== nacc || exp_q.size() != 0)
         begin errors++; $display("FAIL random_drain got=%0d results required=%0d", nfire, nacc); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_dbz();
      test_signed();
      test_stall();
      test_reset_midflight();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
